// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and the packed SR/Cause register payloads with their read formatting.
package cp0_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned EXC_W   = 5;
  localparam int unsigned HWINT_W = 6;

  localparam logic [ADDR_W-1:0] ADDR_SR    = 5'd12;
  localparam logic [ADDR_W-1:0] ADDR_CAUSE = 5'd13;
  localparam logic [ADDR_W-1:0] ADDR_EPC   = 5'd14;
  localparam logic [ADDR_W-1:0] ADDR_PRID  = 5'd15;

  localparam int unsigned SR_IM_LSB     = 10;
  localparam int unsigned SR_EXL_BIT    = 1;
  localparam int unsigned SR_IE_BIT     = 0;
  localparam int unsigned CAUSE_BD_BIT  = 31;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_EXC_LSB = 2;

  localparam logic [DATA_W-1:0] SR_MASK    = 32'h0000_FC03;
  localparam logic [DATA_W-1:0] CAUSE_MASK = 32'h8000_FC7C;

  // Handler entry point lives in D_NPC; kept here as the shared reference value.
  localparam logic [DATA_W-1:0] HANDLER_PC = 32'h0000_4180;

  typedef enum logic [EXC_W-1:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic [HWINT_W-1:0] im;
    logic               exl;
    logic               ie;
  } sr_t;

  typedef struct packed {
    logic               bd;
    logic [HWINT_W-1:0] ip;
    logic [EXC_W-1:0]   exc;
  } cause_t;

  function automatic logic [DATA_W-1:0] sr_word(input sr_t s);
    sr_word = ((DATA_W'(s.im) << SR_IM_LSB)
             | (DATA_W'(s.exl) << SR_EXL_BIT)
             | (DATA_W'(s.ie) << SR_IE_BIT)) & SR_MASK;
  endfunction

  function automatic logic [DATA_W-1:0] cause_word(input cause_t c);
    cause_word = ((DATA_W'(c.bd) << CAUSE_BD_BIT)
                | (DATA_W'(c.ip) << CAUSE_IP_LSB)
                | (DATA_W'(c.exc) << CAUSE_EXC_LSB)) & CAUSE_MASK;
  endfunction

endpackage

// File: rtl/cp0_if.sv
// M-stage <-> CP0 signal bundle: mtc0/mfc0 access, victim info, interrupts,
// and the Req/EPC outputs towards D_NPC and the flush logic.
interface cp0_if;
  import cp0_pkg::*;

  logic                en;
  logic [ADDR_W-1:0]   CP0Addr;
  logic [DATA_W-1:0]   CP0In;
  logic [DATA_W-1:0]   CP0Out;
  logic [DATA_W-1:0]   VPC;
  logic                BDIn;
  logic [EXC_W-1:0]    ExcCodeIn;
  logic [HWINT_W-1:0]  HWInt;
  logic                EXLClr;
  logic [DATA_W-1:0]   EPCOut;
  logic                Req;

  modport master (
    output en, CP0Addr, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    input  CP0Out, EPCOut, Req
  );

  modport slave (
    input  en, CP0Addr, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
    output CP0Out, EPCOut, Req
  );

endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0 exception/interrupt controller: owns SR, Cause, EPC and PRId,
// and raises a one-cycle Req when an enabled interrupt or exception is taken.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [DATA_W-1:0] PRID = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  reset,
  cp0_if.slave  bus
);

  sr_t               sr_q, sr_d;
  cause_t            cause_q, cause_d;
  logic [DATA_W-1:0] epc_q, epc_d;

  logic int_req_c;
  logic exc_req_c;
  logic req_c;

  // EXL masks everything; an interrupt beats a concurrent exception.
  always_comb begin
    int_req_c = (|(bus.HWInt & sr_q.im)) & sr_q.ie & ~sr_q.exl;
    exc_req_c = (bus.ExcCodeIn != '0) & ~sr_q.exl;
    req_c     = (int_req_c | exc_req_c) & ~reset;
  end

  always_comb begin
    sr_d     = sr_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    cause_d.ip = bus.HWInt;

    if (req_c) begin
      // Exception entry; any mtc0 this cycle belongs to a flushed instruction.
      sr_d.exl    = 1'b1;
      cause_d.bd  = bus.BDIn;
      cause_d.exc = int_req_c ? EXC_W'(EXC_INT) : bus.ExcCodeIn;
      epc_d       = bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
    end else begin
      if (bus.en) begin
        case (bus.CP0Addr)
          ADDR_SR: begin
            sr_d.im  = bus.CP0In[SR_IM_LSB +: HWINT_W];
            sr_d.exl = bus.CP0In[SR_EXL_BIT];
            sr_d.ie  = bus.CP0In[SR_IE_BIT];
          end
          ADDR_EPC: epc_d = bus.CP0In;
          default: ;
        endcase
      end
      // eret clears EXL even when a same-cycle mtc0 writes SR.
      if (bus.EXLClr) begin
        sr_d.exl = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      sr_q    <= sr_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  // mfc0 read path shows pre-edge state; no write bypass.
  always_comb begin
    bus.CP0Out = '0;
    case (bus.CP0Addr)
      ADDR_SR:    bus.CP0Out = sr_word(sr_q);
      ADDR_CAUSE: bus.CP0Out = cause_word(cause_q);
      ADDR_EPC:   bus.CP0Out = epc_q;
      ADDR_PRID:  bus.CP0Out = PRID;
      default:    bus.CP0Out = '0;
    endcase
  end

  assign bus.EPCOut = epc_q;
  assign bus.Req    = req_c;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: stimulus queues expected outputs, a monitor
// pops and compares them on the falling edge.
module tb_cp0_unit;
  import cp0_pkg::*;

  localparam logic [31:0] PRID_TB = 32'h0001_8001;
  localparam int K_RD  = 0;
  localparam int K_REQ = 1;
  localparam int K_EPC = 2;

  logic clk;
  logic reset;
  cp0_if bus();

  cp0_unit #(.PRID(PRID_TB)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          kind_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    while (kind_q.size() > 0) begin
      int          k;
      logic [31:0] e;
      logic [31:0] a;
      string       n;
      k = kind_q.pop_front();
      e = exp_q.pop_front();
      n = name_q.pop_front();
      case (k)
        K_RD:    a = bus.CP0Out;
        K_REQ:   a = {31'b0, bus.Req};
        default: a = bus.EPCOut;
      endcase
      vec_cnt++;
      if (a !== e) begin
        err_cnt++;
        $display("FAIL %s: got %h expected %h", n, a, e);
      end
    end
  end

  task automatic push(input int k, input logic [31:0] e, input string n);
    kind_q.push_back(k);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
    bus.CP0Addr = a;
    push(K_RD, e, n);
    sample();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.en      = 1'b1;
    bus.CP0Addr = a;
    bus.CP0In   = d;
    cyc();
    bus.en      = 1'b0;
    bus.CP0In   = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    bus.en        = 1'b0;
    bus.CP0Addr   = '0;
    bus.CP0In     = '0;
    bus.VPC       = '0;
    bus.BDIn      = 1'b0;
    bus.ExcCodeIn = '0;
    bus.HWInt     = '0;
    bus.EXLClr    = 1'b0;

    // Reset state
    cyc(); cyc();
    push(K_REQ, 32'd0, "rst_req");
    push(K_EPC, 32'd0, "rst_epcout");
    sample();
    reset = 1'b0;
    rd(ADDR_SR,    32'h0, "rst_sr");
    rd(ADDR_CAUSE, 32'h0, "rst_cause");
    rd(ADDR_EPC,   32'h0, "rst_epc");
    rd(ADDR_PRID,  PRID_TB, "rst_prid");

    // Interrupt entry
    cyc();
    mtc0(ADDR_SR, 32'h0000_FC03);
    mtc0(ADDR_SR, 32'h0000_0401);
    bus.HWInt = 6'b000001; bus.VPC = 32'h0000_3010; bus.BDIn = 1'b0;
    push(K_REQ, 32'd1, "int_req");
    sample();
    cyc();
    push(K_REQ, 32'd0, "int_req_one_cycle");
    push(K_EPC, 32'h0000_3010, "int_epcout");
    sample();
    rd(ADDR_SR,    32'h0000_0403, "int_sr");
    rd(ADDR_CAUSE, 32'h0000_0400, "int_cause");
    rd(ADDR_EPC,   32'h0000_3010, "int_epc");
    bus.HWInt = '0;

    // Exception in delay slot
    cyc();
    mtc0(ADDR_SR, 32'h0);
    bus.ExcCodeIn = EXC_OV; bus.VPC = 32'h0000_3024; bus.BDIn = 1'b1;
    push(K_REQ, 32'd1, "ov_req");
    sample();
    cyc();
    bus.ExcCodeIn = '0; bus.BDIn = 1'b0;
    push(K_EPC, 32'h0000_3020, "ov_epc_bd");
    push(K_REQ, 32'd0, "ov_req_drop");
    sample();
    rd(ADDR_CAUSE, 32'h8000_0030, "ov_cause");
    rd(ADDR_SR,    32'h0000_0002, "ov_sr_exl");

    // Masked while EXL, then taken after eret
    cyc();
    mtc0(ADDR_SR, 32'h0000_FC03);
    bus.HWInt = 6'h3F; bus.ExcCodeIn = EXC_ADEL; bus.VPC = 32'h0000_3030;
    push(K_REQ, 32'd0, "exl_mask0");
    sample();
    cyc();
    push(K_REQ, 32'd0, "exl_mask1");
    sample();
    cyc();
    bus.EXLClr = 1'b1;
    cyc();
    bus.EXLClr = 1'b0;
    push(K_REQ, 32'd1, "eret_then_req");
    sample();
    cyc();
    push(K_REQ, 32'd0, "eret_req_one_cycle");
    push(K_EPC, 32'h0000_3030, "eret_epc");
    sample();
    rd(ADDR_CAUSE, 32'h0000_FC00, "int_wins_cause");
    bus.HWInt = '0; bus.ExcCodeIn = '0;

    // mtc0 EPC dropped by simultaneous exception
    cyc();
    mtc0(ADDR_SR, 32'h0);
    bus.en = 1'b1; bus.CP0Addr = ADDR_EPC; bus.CP0In = 32'h1234_5678;
    bus.ExcCodeIn = EXC_RI; bus.VPC = 32'h0000_3040;
    push(K_REQ, 32'd1, "ri_req");
    sample();
    cyc();
    bus.en = 1'b0; bus.ExcCodeIn = '0;
    push(K_EPC, 32'h0000_3040, "ri_mtc0_dropped");
    sample();
    rd(ADDR_CAUSE, 32'h0000_0028, "ri_cause");

    // eret with concurrent mtc0 EPC: both happen
    cyc();
    bus.EXLClr = 1'b1;
    mtc0(ADDR_EPC, 32'hCAFE_0000);
    bus.EXLClr = 1'b0;
    push(K_EPC, 32'hCAFE_0000, "eret_mtc0_epc");
    sample();
    rd(ADDR_SR, 32'h0, "eret_mtc0_sr");

    // EPC wrap for delay slot at address 0
    cyc();
    bus.ExcCodeIn = EXC_ADES; bus.VPC = 32'h0; bus.BDIn = 1'b1;
    push(K_REQ, 32'd1, "wrap_req");
    sample();
    cyc();
    bus.ExcCodeIn = '0; bus.BDIn = 1'b0;
    push(K_EPC, 32'hFFFF_FFFC, "wrap_epc");
    sample();
    rd(ADDR_CAUSE, 32'h8000_0014, "wrap_cause");

    // Cause is read-only; async reset clears without an edge
    cyc();
    bus.HWInt = 6'b100000;
    mtc0(ADDR_CAUSE, 32'hFFFF_FFFF);
    rd(ADDR_CAUSE, 32'h8000_8014, "cause_ro");
    cyc();
    reset = 1'b1;
    bus.ExcCodeIn = EXC_OV;
    bus.CP0Addr = ADDR_EPC;
    push(K_RD,  32'h0, "async_rst_epc");
    push(K_EPC, 32'h0, "async_rst_epcout");
    push(K_REQ, 32'd0, "async_rst_req");
    sample();
    rd(ADDR_SR,    32'h0, "rst_hold_sr");
    rd(ADDR_CAUSE, 32'h0, "rst_hold_cause");
    bus.ExcCodeIn = '0;
    reset = 1'b0;
    cyc();
    mtc0(ADDR_CAUSE, 32'hFFFF_FFFF);
    rd(ADDR_CAUSE, 32'h0000_8000, "cause_ip_only");
    rd(ADDR_EPC,   32'h0, "post_rst_epc");
    rd(ADDR_PRID,  PRID_TB, "post_rst_prid");
    rd(5'd3,       32'h0, "unmapped_addr");

    cyc();
    if (kind_q.size() != 0) begin
      err_cnt++;
      $display("FAIL drain: got %0d pending expected 0", kind_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
